// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first; done pulses WIDTH edges after the accepting start.
// start is accepted only while busy=0 (including the done cycle); starts during a run are dropped.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  always_comb begin
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    c_next   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    // The new bit enters from the MSB side; the widened vector keeps WIDTH=1 legal.
    s_ext    = {s_bit, s_sr};
    s_next   = s_ext[WIDTH:1];
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_sr  <= s_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= c_next;
          if (last_bit) begin
            sum       <= s_next;
            carry_out <= c_next;
            done      <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1: directed scenarios plus random regression
// against plain a+b arithmetic and a fixed WIDTH-cycle latency.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8;

  logic       start1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; returns edges until done and busy-high samples seen.
  task automatic wait_done(input bit w1, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (((w1 ? done1 : done8) !== 1'b1) && n < 100) begin
      if ((w1 ? busy1 : busy8) === 1'b1) bc++;
      tick();
      n++;
    end
  endtask

  task automatic accept8(input logic [7:0] av, input logic [7:0] bv);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  initial begin
    int n, bc, dcount;
    logic [8:0] exp9;
    logic [1:0] exp2;
    logic [7:0] ra, rb;
    logic [0:0] qa, qb;

    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (3) tick();
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_sum", 64'({cout8, sum8}), 64'd0);
    check("reset_w1", 64'({busy1, done1, cout1, sum1}), 64'd0);
    rst = 1'b0;
    tick();

    // 5 + 3
    accept8(8'h05, 8'h03);
    wait_done(1'b0, n, bc);
    check("add53_latency", 64'(n), 64'd8);
    check("add53_busy_cycles", 64'(bc), 64'd8);
    check("add53_result", 64'({cout8, sum8}), 64'h008);
    check("add53_busy_at_done", 64'(busy8), 64'd0);
    tick();
    check("add53_done_pulse", 64'(done8), 64'd0);
    check("add53_hold", 64'({cout8, sum8}), 64'h008);

    accept8(8'hFF, 8'h01);
    wait_done(1'b0, n, bc);
    check("addFF01_result", 64'({cout8, sum8}), 64'h100);
    tick();

    accept8(8'hFF, 8'hFF);
    wait_done(1'b0, n, bc);
    check("addFFFF_result", 64'({cout8, sum8}), 64'h1FE);
    // Start in the done cycle: back-to-back with the previous result still visible.
    a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
    check("b2b_first_valid", 64'({done8, cout8, sum8}), 64'h3FE);
    tick();
    start8 = 1'b0;
    check("b2b_busy_rises", 64'({busy8, done8}), 64'h2);
    wait_done(1'b0, n, bc);
    check("b2b_latency", 64'(n), 64'd8);
    check("b2b_result", 64'({cout8, sum8}), 64'h080);
    tick();

    // Start pulse during busy must be ignored.
    accept8(8'h10, 8'h20);
    tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dcount = 0;
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin tick(); n++; end
    check("ignore_result", 64'({cout8, sum8}), 64'h030);
    check("ignore_latency", 64'(n + 3), 64'd8);
    repeat (12) begin tick(); if (done8 === 1'b1) dcount++; end
    check("ignore_single_done", 64'(dcount), 64'd0);
    check("ignore_idle", 64'(busy8), 64'd0);

    // Reset mid-operation.
    accept8(8'hC3, 8'h3C);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs", 64'({busy8, done8, cout8, sum8}), 64'd0);
    dcount = 0;
    repeat (12) begin tick(); if (done8 === 1'b1) dcount++; end
    check("midrst_no_done", 64'(dcount), 64'd0);
    accept8(8'hC3, 8'h3C);
    wait_done(1'b0, n, bc);
    check("midrst_fresh_latency", 64'(n), 64'd8);
    check("midrst_fresh_result", 64'({cout8, sum8}), 64'h0FF);
    tick();

    // start together with rst is dropped.
    rst = 1'b1; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    tick();
    check("rst_start_ignored", 64'({busy8, done8, cout8, sum8}), 64'd0);

    // Random regression, WIDTH=8; gap 0 starts in the done cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb};
      accept8(ra, rb);
      wait_done(1'b0, n, bc);
      check("rand8_latency", 64'(n), 64'd8);
      check("rand8_result", 64'({cout8, sum8}), 64'(exp9));
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    // WIDTH=1: done on the edge after acceptance.
    for (int i = 0; i < 1000; i++) begin
      qa = 1'($urandom); qb = 1'($urandom);
      exp2 = {1'b0, qa} + {1'b0, qb};
      a1 = qa; b1 = qb; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom);
      wait_done(1'b1, n, bc);
      check("rand1_latency", 64'(n), 64'd1);
      check("rand1_result", 64'({cout1, sum1}), 64'(exp2));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
